// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared definitions for the iterative RV32M divider.
//   - DIV_* operation encodings driven on div_unit.op
//   - WB_DIV write-back select so the register-file write mux picks the
//     divider result
//   - divider FSM state encodings
//   - mag32 helper: two's-complement magnitude / conditional negation
package div_unit_pkg;

    // Operation encoding: op[1] selects remainder, op[0] selects unsigned.
    localparam logic [1:0] DIV_DIV  = 2'b00;
    localparam logic [1:0] DIV_DIVU = 2'b01;
    localparam logic [1:0] DIV_REM  = 2'b10;
    localparam logic [1:0] DIV_REMU = 2'b11;

    // Register-file write-back mux select for the divider result.
    localparam logic [2:0] WB_DIV = 3'd5;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Returns -v when neg is set, v otherwise. Used both for taking the
    // magnitude of signed operands and for the final sign fix.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// div_unit: radix-2 restoring divider for RV32M div/divu/rem/remu.
// One quotient bit per cycle (32 CALC cycles); divide-by-zero and signed
// overflow finish in a single cycle without entering CALC.
//
// Ports:
//   clk     in   clock, rising edge
//   rst     in   asynchronous active-high reset
//   start   in   request a division (accepted in IDLE or DONE)
//   op      in   [1:0] DIV_* operation
//   a       in   [31:0] dividend (rD1)
//   b       in   [31:0] divisor (rD2)
//   rd_in   in   [4:0] destination register tag
//   flush   in   abort the current operation (beats start and iteration)
//   busy    out  high while iterating
//   stall   out  holds upstream stages while a division is pending
//   done    out  one-cycle pulse, result/rd_out valid
//   result  out  [31:0] quotient or remainder
//   rd_out  out  [4:0] destination tag for write-back
module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    input  logic            flush,
    output logic            busy,
    output logic            stall,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    div_state_e      state_q, state_d;
    logic [XLEN-1:0] dvd_q, dvd_d;       // dividend magnitude, shifted out MSB first
    logic [XLEN-1:0] dvs_q, dvs_d;       // divisor magnitude
    logic [XLEN:0]   rem_q, rem_d;       // 33-bit partial remainder
    logic [XLEN-1:0] quo_q, quo_d;       // quotient bits collected so far
    logic [4:0]      cnt_q, cnt_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            rem_sel_q, rem_sel_d;  // op[1]: return remainder
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_out_q, rd_out_d;

    // Request decode
    logic            is_signed;
    logic            b_zero;
    logic            ovf;
    logic            fast;
    logic            accept;
    logic [XLEN-1:0] fast_res;

    assign is_signed = ~op[0];
    assign b_zero    = (b == '0);
    assign ovf       = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign fast      = b_zero | ovf;
    assign accept    = start && (state_q != DIV_CALC) && !flush;

    always_comb begin
        fast_res = '0;
        if (b_zero) begin
            fast_res = op[1] ? a : '1;
        end else if (ovf) begin
            fast_res = op[1] ? '0 : 32'h8000_0000;
        end
    end

    // One restoring step. The shifted remainder is widened by one bit so
    // the borrow of the trial subtraction lands in the top bit.
    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;
    logic            take;
    logic [XLEN:0]   rem_next;
    logic [XLEN-1:0] quo_next;
    logic [XLEN-1:0] quo_fix;
    logic [XLEN-1:0] rem_fix;

    assign shifted  = {rem_q, dvd_q[XLEN-1]};
    assign trial    = shifted - {2'b00, dvs_q};
    assign take     = ~trial[XLEN+1];
    assign rem_next = take ? trial[XLEN:0] : shifted[XLEN:0];
    assign quo_next = {quo_q[XLEN-2:0], take};
    // q_neg/r_neg are only ever set for signed ops, so unsigned results
    // pass through unchanged.
    assign quo_fix  = mag32(quo_next, q_neg_q);
    assign rem_fix  = mag32(rem_next[XLEN-1:0], r_neg_q);

    always_comb begin
        state_d   = state_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        cnt_d     = cnt_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        rem_sel_d = rem_sel_q;
        rd_d      = rd_q;
        result_d  = result_q;
        rd_out_d  = rd_out_q;

        if (flush) begin
            // Abort: no done, result/rd_out keep their previous values.
            state_d = DIV_IDLE;
        end else if (accept) begin
            rem_sel_d = op[1];
            rd_d      = rd_in;
            dvd_d     = mag32(a, is_signed & a[XLEN-1]);
            dvs_d     = mag32(b, is_signed & b[XLEN-1]);
            q_neg_d   = is_signed & (a[XLEN-1] ^ b[XLEN-1]);
            r_neg_d   = is_signed & a[XLEN-1];
            rem_d     = '0;
            quo_d     = '0;
            cnt_d     = 5'd31;
            if (fast) begin
                result_d = fast_res;
                rd_out_d = rd_in;
                state_d  = DIV_DONE;
            end else begin
                state_d  = DIV_CALC;
            end
        end else begin
            case (state_q)
                DIV_CALC: begin
                    rem_d = rem_next;
                    quo_d = quo_next;
                    dvd_d = dvd_q << 1;
                    cnt_d = cnt_q - 5'd1;
                    if (cnt_q == 5'd0) begin
                        result_d = rem_sel_q ? rem_fix : quo_fix;
                        rd_out_d = rd_q;
                        state_d  = DIV_DONE;
                    end
                end
                DIV_DONE: state_d = DIV_IDLE;
                default:  state_d = DIV_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DIV_IDLE;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            rem_sel_q <= 1'b0;
            rd_q      <= '0;
            result_q  <= '0;
            rd_out_q  <= '0;
        end else begin
            state_q   <= state_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            cnt_q     <= cnt_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            rem_sel_q <= rem_sel_d;
            rd_q      <= rd_d;
            result_q  <= result_d;
            rd_out_q  <= rd_out_d;
        end
    end

    assign busy   = (state_q == DIV_CALC);
    assign done   = (state_q == DIV_DONE);
    // Only a slow-path request stalls in its own start cycle.
    assign stall  = busy | (start & ~busy & ~fast);
    assign result = result_q;
    assign rd_out = rd_out_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Stimulus pushes the expected
// result, tag and done cycle; a negedge monitor pops on every done pulse.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        flush;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .flush  (flush),
        .busy   (busy),
        .stall  (stall),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          dcyc;
    } exp_t;

    exp_t sb[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
                chk("done_cycle", cyc, e.dcyc);
                $display("[TB] done: result=%h rd=%0d cycle=%0d (expected %h rd=%0d cycle=%0d)",
                         result, rd_out, cyc, e.res, e.rd, e.dcyc);
            end
        end
    end

    // Called at a negedge. Leaves start low just after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input logic [4:0] rdv, input logic [31:0] ex, input bit is_fast,
                         input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        rd_in = rdv;
        e.res  = ex;
        e.rd   = rdv;
        e.dcyc = cyc + 1 + (is_fast ? 0 : 32);
        if (push) sb.push_back(e);
        #1;
        chk("stall_at_start", {31'd0, stall}, {31'd0, !is_fast});
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall && !busy) chk("stall_without_request", {31'd0, stall}, 32'd0);
            if (done) return;
        end
        chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    localparam int NV = 14;
    logic [1:0]  v_op  [NV] = '{DIV_DIVU, DIV_REMU, DIV_DIV, DIV_REM, DIV_DIVU,
                                DIV_DIV, DIV_REM, DIV_DIVU, DIV_REMU,
                                DIV_DIV, DIV_REM, DIV_DIVU, DIV_REMU, DIV_REM};
    logic [31:0] v_a   [NV] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd123, 32'd123, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'd7};
    logic [31:0] v_b   [NV] = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd2,
                                32'd0, 32'd0, 32'd0, 32'd0,
                                32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFFE};
    logic [31:0] v_exp [NV] = '{32'd14, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC,
                                32'hFFFF_FFFF, 32'd123, 32'hFFFF_FFFF, 32'd5,
                                32'h8000_0000, 32'd0, 32'd0, 32'h8000_0000, 32'd1};
    bit          v_fast[NV] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0, 0, 0};

    initial begin
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; rd_in = '0; flush = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy",   {31'd0, busy},  32'd0);
        chk("reset_stall",  {31'd0, stall}, 32'd0);
        chk("reset_done",   {31'd0, done},  32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_rd_out", {27'd0, rd_out}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            issue(v_op[i], v_a[i], v_b[i], 5'(i + 5), v_exp[i], v_fast[i], 1'b1);
            wait_done("vector");
            $display("[TB] vector %0d: op=%0d a=%h b=%h expected %h", i, v_op[i], v_a[i], v_b[i], v_exp[i]);
        end
        @(negedge clk);

        // Back-to-back: second start lands in the DONE cycle of the first.
        issue(DIV_DIVU, 32'd100, 32'd7, 5'd5, 32'd14, 1'b0, 1'b1);
        wait_done("b2b_first");
        issue(DIV_DIVU, 32'd50, 32'd5, 5'd6, 32'd10, 1'b0, 1'b1);
        repeat (5) @(negedge clk);
        // Ignored start pulse during CALC (would be a fast path if accepted).
        start = 1'b1; op = DIV_DIVU; a = 32'd1; b = 32'd0; rd_in = 5'd30;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_ignored_start", {31'd0, busy}, 32'd1);
        wait_done("b2b_second");
        $display("[TB] back-to-back 100/7 then 50/5 complete");
        @(negedge clk);

        // Reset in the middle of CALC.
        issue(DIV_DIVU, 32'd1000, 32'd3, 5'd11, 32'd0, 1'b0, 1'b0);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy",   {31'd0, busy},  32'd0);
        chk("midrst_stall",  {31'd0, stall}, 32'd0);
        chk("midrst_done",   {31'd0, done},  32'd0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_rd_out", {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(DIV_DIVU, 32'd9, 32'd3, 5'd9, 32'd3, 1'b0, 1'b1);
        wait_done("after_reset");
        $display("[TB] reset mid-operation then divu 9/3 complete");
        @(negedge clk);

        // Flush 10 cycles into CALC.
        issue(DIV_DIVU, 32'd1000, 32'd3, 5'd12, 32'd0, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy",   {31'd0, busy}, 32'd0);
        chk("flush_done",   {31'd0, done}, 32'd0);
        chk("flush_result", result, 32'd3);
        chk("flush_rd_out", {27'd0, rd_out}, 32'd9);
        $display("[TB] flush: busy=%0d done=%0d result=%h rd=%0d", busy, done, result, rd_out);
        repeat (40) @(negedge clk);

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit divider for the RV32M `div`/`divu`/`rem`/`remu` instructions. It sits directly downstream of the register file: it takes the two read ports (`rD1`, `rD2`) as operands and produces a value for the register-file write-back select. While a division runs, it holds the pipeline through `stall`. It uses a radix-2 restoring algorithm, one quotient bit per cycle, with single-cycle fast paths for the architectural corner cases.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; only 32 is supported.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request a division this cycle; sampled only when accepted.
- `op`  in  2  operation, using the `DIV_*` encoding.
- `a`  in  32  dividend, from `rD1`.
- `b`  in  32  divisor, from `rD2`.
- `rd_in`  in  5  destination register tag, captured with the operands.
- `flush`  in  1  abort the current operation.
- `busy`  out  1  high while iterating (CALC).
- `stall`  out  1  `busy | (start & ~busy & ~fast)`; freezes the upstream stages.
- `done`  out  1  one-cycle pulse when `result` is valid.
- `result`  out  32  quotient or remainder, valid while `done` is high.
- `rd_out`  out  5  tag for the write-back, valid while `done` is high.

## Operation
- States: IDLE, CALC, DONE.
- A start is accepted when the state is IDLE or DONE and `start` is high (back-to-back operation is allowed). At the accepting edge:
  - latch `op` and `rd_in`;
  - latch the absolute values of `a` and `b` for signed ops, or the raw values for unsigned ops;
  - record `q_neg` = `a[31]^b[31]` and `r_neg` = `a[31]` (both signed ops only);
  - clear the 33-bit partial remainder and load the counter with 31.
- Fast paths skip CALC and go straight to DONE, with `result` latched at the accepting edge:
  - `b` == 0: `div`/`divu` return 0xFFFFFFFF; `rem`/`remu` return `a`.
  - signed overflow (`a` = 0x80000000, `b` = 0xFFFFFFFF, op `div`/`rem`): `div` returns 0x80000000; `rem` returns 0.
- CALC performs one iteration per edge:
  - shift the partial remainder left, bringing in the next dividend MSB;
  - trial-subtract the divisor; if the result is non-negative, keep it and shift 1 into the quotient, otherwise shift 0;
  - decrement the counter;
  - on the iteration where the counter is 0, latch the sign-fixed `result` and go to DONE.
- Sign fix: the quotient is negated if `q_neg`; the remainder is negated if `r_neg`. Unsigned ops are never negated.
- DONE lasts one cycle. The next state is CALC or DONE on a new accepted start, otherwise IDLE.
- `start` while in CALC is ignored. Upstream never asserts it, because `stall` is high.
- `flush` has priority over `start` and over iteration:
  - the next state is IDLE;
  - `done` is suppressed for the aborted operation;
  - `result` and `rd_out` keep their old values.
- Reset: the state goes to IDLE. `busy`, `stall`, `done`, `result`, `rd_out`, the counter and all datapath registers go to 0. This applies mid-operation too; no `done` is issued.

## Timing
- Call the edge that accepts `start` E0.
- Normal path:
  - `busy` is high in the cycles after E0 through E32;
  - `done` is high in the cycle after E32, i.e. 33 cycles after the start cycle;
  - `stall` is high from the start cycle through the last CALC cycle.
- Fast path: `done` is high in the cycle right after E0; `stall` is not asserted.
- `result` and `rd_out` are registered outputs with no combinational path from the inputs. `done` is decoded from the state register.
- Throughput: one operation per 33 cycles. With back-to-back starts, the DONE cycle of one operation is the start cycle of the next.

## Structure
- Shared defines header:
  - `DIV_DIV` 2'b00, `DIV_DIVU` 2'b01, `DIV_REM` 2'b10, `DIV_REMU` 2'b11;
  - new write-back select constant `WB_DIV`, so the register-file write mux picks `result`;
  - state encodings `DIV_IDLE`, `DIV_CALC`, `DIV_DONE`.
- There is no sub-module: the magnitude/negation logic and the iteration datapath live in this module.

## Test plan
- `divu`, `a`=100, `b`=7, `rd_in`=5 -> `done` 33 cycles after start; `result`=14, `rd_out`=5. With `remu` -> 2.
- `div` -7/2 -> 0xFFFFFFFD. `rem` -7/2 -> 0xFFFFFFFF. `divu` 0xFFFFFFF9/2 -> 0x7FFFFFFC.
- `div` 123/0 -> `done` 1 cycle after start, `result`=0xFFFFFFFF, `stall` never high. `rem` 123/0 -> 123.
- `div` 0x80000000/0xFFFFFFFF -> 0x80000000 on the fast path. `rem` with the same operands -> 0.
- `flush` at cycle 10 of CALC -> IDLE next cycle, no `done`. Reset asserted at cycle 20 -> all outputs 0 immediately. A new `divu` 9/3 afterwards -> 3.
- Back-to-back: a start during the DONE of 100/7, with 50/5 -> second `done` 33 cycles later with 10. A `start` pulse during CALC has no effect.
